pipe_hazard_ctrl: RTL and testbench

Stall/flush sequencer for the five-stage MIPS pipeline. It sits beside the F/D, D/E, E/M and M/W pipeline registers and produces the PC and F/D enables and the D/E clear. It also owns a multi-cycle mult/div busy sequencer that decides when HI/LO-class instructions may leave D. It detects load-use hazards between E and D, tracks the HI/LO unit's busy window with a counter-based FSM, and freezes the front of the pipe while inserting bubbles into E.

---
 rtl/pipe_hazard_ctrl_if.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if;
  logic [31:0] instr_d;
  logic [31:0] instr_e;
  logic [4:0]  write_reg_e;
  logic        pc_en;
  logic        fd_en;
  logic        de_clr;
  logic        md_start;
  logic        md_busy;
  logic [3:0]  md_cnt;

  modport master (
    output instr_d, instr_e, write_reg_e,
    input  pc_en, fd_en, de_clr, md_start, md_busy, md_cnt
  );

  modport slave (
    input  instr_d, instr_e, write_reg_e,
    output pc_en, fd_en, de_clr, md_start, md_busy, md_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage MIPS pipe: load-use detection
// between E and D plus the HI/LO mult/div busy-window FSM.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult
    $error("MULT_CYCLES must be in 1..15 to fit the 4-bit md_cnt");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("DIV_CYCLES must be in 1..15 to fit the 4-bit md_cnt");
  end

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [3:0] MULT_LD    = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD     = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic [5:0] w_op_d;
  logic [5:0] w_op_e;
  logic [4:0] w_rs_d;
  logic [4:0] w_rt_d;
  logic [5:0] w_funct_d;
  logic [5:0] w_funct_e;
  logic       w_lw_e;
  logic       w_md_op_e;
  logic       w_div_e;
  logic       w_hilo_d;
  logic       w_load_use;
  logic       w_busy;
  logic       w_md_start;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_unused_bits;

  assign w_op_d    = bus.instr_d[31:26];
  assign w_rs_d    = bus.instr_d[25:21];
  assign w_rt_d    = bus.instr_d[20:16];
  assign w_funct_d = bus.instr_d[5:0];
  assign w_op_e    = bus.instr_e[31:26];
  assign w_funct_e = bus.instr_e[5:0];

  // Register-number and immediate fields that never take part in a hazard decision.
  assign w_unused_bits = ^{bus.instr_d[15:6], bus.instr_e[25:6]};

  assign w_lw_e    = (w_op_e == OP_LW);
  assign w_md_op_e = (w_op_e == OP_SPECIAL) &&
                     (w_funct_e inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  assign w_div_e   = w_funct_e inside {FN_DIV, FN_DIVU};
  assign w_hilo_d  = (w_op_d == OP_SPECIAL) &&
                     (w_funct_d inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                                        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});

  // Conservative: any rs/rt match counts even if instr_d ignores that field.
  assign w_load_use = w_lw_e && (bus.write_reg_e != 5'd0) &&
                      ((bus.write_reg_e == w_rs_d) || (bus.write_reg_e == w_rt_d));

  assign w_busy     = (r_state == S_BUSY);
  assign w_md_start = w_md_op_e && (r_state == S_IDLE);
  assign w_md_stall = w_hilo_d && (w_md_start || w_busy);
  assign w_stall    = w_load_use || w_md_stall;

  assign bus.pc_en    = ~w_stall;
  assign bus.fd_en    = ~w_stall;
  assign bus.de_clr   = w_stall;
  assign bus.md_start = w_md_start;
  assign bus.md_busy  = w_busy;
  assign bus.md_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A mult/div seen in E while busy is ignored: no start, no reload.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_md_start) begin
          w_cnt_nxt   = w_div_e ? DIV_LD : MULT_LD;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed pipeline scenarios plus
// random raw D/E traffic against a busy-window reference model.
module tb_pipe_hazard_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;
    int         cyc;
    int         sid;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   obs_stall = 0;
  int   obs_busy  = 0;
  int   sid = 0;

  // Reference model: the unit is busy during cycles (start, busy_end].
  int cyc = 0;
  int busy_end = -1;
  logic [31:0] prog[$];

  function automatic logic is_lw(input logic [31:0] x);
    return x[31:26] == 6'b100011;
  endfunction
  function automatic logic is_md(input logic [31:0] x);
    return x[31:26] == 6'd0 && (x[5:0] == 6'b011000 || x[5:0] == 6'b011001 ||
                                x[5:0] == 6'b011010 || x[5:0] == 6'b011011);
  endfunction
  function automatic logic is_hilo(input logic [31:0] x);
    return is_md(x) || (x[31:26] == 6'd0 && (x[5:0] == 6'b010000 || x[5:0] == 6'b010001 ||
                                            x[5:0] == 6'b010010 || x[5:0] == 6'b010011));
  endfunction
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] lw(input int rt, input int rs);
    return {6'b100011, 5'(rs), 5'(rt), 16'h0010};
  endfunction
  function automatic logic [4:0] dest(input logic [31:0] x);
    if (is_lw(x)) return x[20:16];
    if (x[31:26] == 6'd0) return x[15:11];
    return 5'd0;
  endfunction

  task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [4:0] wr,
                      input logic rst, input bit chk, output logic stall_o);
    logic busy, start, lu;
    int   cnt;
    exp_t ex;
    @(posedge clk);
    #1;
    bus.instr_d     = d;
    bus.instr_e     = e;
    bus.write_reg_e = wr;
    reset           = rst;
    busy  = (cyc <= busy_end);
    cnt   = busy ? (busy_end - cyc + 1) : 0;
    start = is_md(e) && !busy;
    lu    = is_lw(e) && wr != 5'd0 && (wr == d[25:21] || wr == d[20:16]);
    stall_o = lu || (is_hilo(d) && (start || busy));
    if (chk) begin
      ex.v   = {~stall_o, ~stall_o, stall_o, start, busy, 4'(cnt)};
      ex.cyc = cyc;
      ex.sid = sid;
      q.push_back(ex);
    end
    if (rst) busy_end = cyc;
    else if (start) busy_end = cyc + (e[5:0] inside {6'b011010, 6'b011011} ? DIV_N : MULT_N);
    cyc++;
  endtask

  // Feeds prog through D and E, holding D and bubbling E whenever a stall is expected.
  task automatic run_prog(input int tail);
    logic [31:0] cd, ce;
    logic st;
    cd = 32'd0;
    ce = 32'd0;
    while (prog.size() > 0 || cd != 32'd0 || ce != 32'd0) begin
      step(cd, ce, dest(ce), 1'b0, 1'b1, st);
      if (st) ce = 32'd0;
      else begin
        ce = cd;
        cd = (prog.size() > 0) ? prog.pop_front() : 32'd0;
      end
    end
    repeat (tail) step(32'd0, 32'd0, 5'd0, 1'b0, 1'b1, st);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int r1, r2, r3;
    r1 = $urandom_range(0, 3);
    r2 = $urandom_range(0, 3);
    r3 = $urandom_range(0, 3);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1, 6: return lw(r1, r2);
      2: return rtype(r1, r2, r3, 6'b100001);
      3: return rtype(r1, r2, 0, 6'(6'b011000 + $urandom_range(0, 3)));
      4, 7: return rtype(r1, r2, r3, 6'(6'b010000 + $urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    exp_t ex;
    logic [8:0] got;
    got = {bus.pc_en, bus.fd_en, bus.de_clr, bus.md_start, bus.md_busy, bus.md_cnt};
    if (bus.de_clr === 1'b1) obs_stall <= obs_stall + 1;
    if (bus.md_busy === 1'b1) obs_busy <= obs_busy + 1;
    if (q.size() > 0) begin
      ex = q.pop_front();
      checks <= checks + 1;
      if (got !== ex.v) begin
        errors <= errors + 1;
        $display("FAIL scn%0d cyc%0d outputs: got pc/fd/clr/start/busy/cnt=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                 ex.sid, ex.cyc, got[8], got[7], got[6], got[5], got[4], got[3:0],
                 ex.v[8], ex.v[7], ex.v[6], ex.v[5], ex.v[4], ex.v[3:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic st;
    int s0, b0;
    reset = 1'b1;
    bus.instr_d = 32'd0;
    bus.instr_e = 32'd0;
    bus.write_reg_e = 5'd0;
    step(32'd0, 32'd0, 5'd0, 1'b1, 1'b0, st);
    step(32'd0, 32'd0, 5'd0, 1'b1, 1'b0, st);
    sid = 1;
    repeat (2) step(32'd0, 32'd0, 5'd0, 1'b0, 1'b1, st);

    // Reset in the middle of a divide, in the cycle md_cnt shows 7.
    sid = 2;
    settle(); b0 = obs_busy;
    step(32'd0, rtype(2, 3, 0, 6'b011011), 5'd0, 1'b0, 1'b1, st);
    repeat (3) step(32'd0, 32'd0, 5'd0, 1'b0, 1'b1, st);
    step(32'd0, 32'd0, 5'd0, 1'b1, 1'b1, st);
    repeat (3) step(32'd0, 32'd0, 5'd0, 1'b0, 1'b1, st);
    settle(); check_int("reset_abort_busy_cycles", obs_busy - b0, 4);

    sid = 3;
    settle(); s0 = obs_stall;
    prog = '{lw(8, 1), rtype(8, 10, 9, 6'b100000)};
    run_prog(2);
    settle(); check_int("load_use_stalls", obs_stall - s0, 1);

    sid = 4;
    settle(); s0 = obs_stall;
    prog = '{lw(0, 1), rtype(0, 10, 9, 6'b100000)};
    run_prog(2);
    settle(); check_int("lw_r0_no_stall", obs_stall - s0, 0);

    sid = 5;
    settle(); s0 = obs_stall; b0 = obs_busy;
    prog = '{rtype(2, 3, 0, 6'b011000), rtype(0, 0, 4, 6'b010010)};
    run_prog(2);
    settle();
    check_int("mult_mflo_stalls", obs_stall - s0, MULT_N + 1);
    check_int("mult_busy_cycles", obs_busy - b0, MULT_N);

    sid = 6;
    settle(); s0 = obs_stall; b0 = obs_busy;
    prog = '{rtype(2, 3, 0, 6'b011011), rtype(5, 6, 7, 6'b100001),
             rtype(7, 6, 8, 6'b100001), rtype(8, 5, 9, 6'b100001)};
    run_prog(12);
    settle();
    check_int("divu_addu_stalls", obs_stall - s0, 0);
    check_int("divu_busy_cycles", obs_busy - b0, DIV_N);

    sid = 7;
    settle(); s0 = obs_stall;
    prog = '{rtype(2, 3, 0, 6'b011000), lw(4, 5), rtype(4, 0, 0, 6'b010001)};
    run_prog(3);
    settle(); check_int("lw_and_busy_single_stall", obs_stall - s0, MULT_N);

    sid = 8;
    settle(); s0 = obs_stall; b0 = obs_busy;
    prog = '{rtype(2, 3, 0, 6'b011000), rtype(4, 5, 0, 6'b011010)};
    run_prog(12);
    settle();
    check_int("mult_div_b2b_stalls", obs_stall - s0, MULT_N + 1);
    check_int("mult_div_b2b_busy", obs_busy - b0, MULT_N + DIV_N);

    // Random raw D/E traffic, including mult/div in E while busy and stray resets.
    sid = 9;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d, e;
      logic [4:0] wr;
      d  = rand_instr();
      e  = ($urandom_range(0, 3) == 0) ? 32'd0 : rand_instr();
      wr = is_lw(e) ? e[20:16] : 5'($urandom_range(0, 3));
      step(d, e, wr, ($urandom_range(0, 59) == 0), 1'b1, st);
    end
    repeat (2) step(32'd0, 32'd0, 5'd0, 1'b1, 1'b0, st);
    settle();
    check_int("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
